fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of decode. Decode slices the 6-bit opcode from the fetched word and drives the opcode-to-control decoder.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid flag.
- Handles branch/jump redirects from EXE and freeze (stall) from the hazard unit.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Decode slices the opcode using the OPCODE_* bounds below.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_INST_W = 32;
  localparam int DEFAULT_DEPTH  = 2;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Opcode 0 decodes to all-zero control, so an empty stage looks like a NOP.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs between imem and decode.
// flush wins over push/pop; head is combinational from storage.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !is_empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push  = push && (!is_full || do_pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requester and fetch buffer.
// Redirects from EXE flush the buffer and discard any in-flight response.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int INST_W = DEFAULT_INST_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              freeze,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output fetch_state_t      dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  // Handshake: a request transfers on a cycle with imem_req && imem_gnt; its
  // data returns on the first later cycle with imem_rvalid. Only one request
  // is ever outstanding, so rvalid needs no tag. Decode consumes the head on
  // any cycle with if_valid && !freeze && !branch_taken.

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              has_room;
  logic              push;
  logic              pop;

  assign has_room  = (count < CNT_W'(DEPTH));
  assign imem_req  = !rst && (state == REQ) && has_room && !branch_taken;
  assign imem_addr = pc;
  assign dbg_state = state;

  assign push = (state == WAIT) && imem_rvalid && !branch_taken;
  assign pop  = if_valid && !freeze && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REQ;
      pc     <= ADDR_W'(PC_RESET);
      req_pc <= ADDR_W'(PC_RESET);
    end else if (branch_taken) begin
      pc <= branch_target;
      // An in-flight response belongs to the old path and must be swallowed.
      case (state)
        WAIT:    state <= imem_rvalid ? REQ : DROP;
        DROP:    state <= imem_rvalid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_req && imem_gnt) begin
            req_pc <= pc;
            pc     <= pc + ADDR_W'(PC_STEP);
            state  <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state <= REQ;
        DROP:    if (imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (push),
    .din   ({req_pc, imem_rdata}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign if_valid = (count != '0);
  assign if_inst  = if_valid ? head[INST_W-1:0] : INST_W'(NOP_INST);
  assign if_pc    = if_valid ? head[ENT_W-1:INST_W] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: the bench plays instruction memory and
// keeps a queue-level model of the fetch buffer contents and the next PC.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          freeze;
  logic          if_valid;
  logic [IW-1:0] if_inst;
  logic [AW-1:0] if_pc;
  fetch_state_t  dbg_state;

  fetch_stage #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .freeze        (freeze),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    exp_pc;
  logic             outstanding;
  logic             killed;
  logic [AW-1:0]    out_addr;
  int               lat_left;

  // stimulus knobs
  int          gnt_pct, frz_pct, br_permil, lat_min, lat_max;
  logic        rand_data, force_br, stray_rv, opc_chk, dbf_chk;
  logic [AW-1:0] force_tgt;

  int checks;
  int failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      branch_taken = 1'b0; branch_target = '0; freeze = 1'b0;
      @(negedge clk);
      check("req_in_reset", imem_req, 1'b0);
      @(posedge clk);
      exp_q.delete();
      exp_pc = '0;
      outstanding = 1'b0;
      killed = 1'b0;
      #1;
    end
    rst = 1'b0;
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_inst", if_inst, '0);
    check("rst_if_pc", if_pc, '0);
    check("rst_pc", imem_addr, '0);
  endtask

  task automatic step();
    logic granted, rv, exp_req;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    freeze = ($urandom_range(99) < frz_pct);
    branch_taken = force_br || ($urandom_range(999) < br_permil);
    branch_target = force_br ? force_tgt : ($urandom() & 32'hFFFF_FFFC);
    rv = 1'b0;
    if (outstanding && lat_left == 0) begin
      rv = 1'b1;
      if (rand_data) imem_rdata = $urandom();
      else imem_rdata = killed ? 32'hDEAD_BEEF : (out_addr | 32'h0400_0000);
    end else if (stray_rv) begin
      rv = 1'b1;
      imem_rdata = 32'hBAD0_0001;
    end else begin
      imem_rdata = $urandom();
    end
    imem_rvalid = rv;
    @(negedge clk);
    exp_req = !outstanding && (exp_q.size() < DEPTH) && !branch_taken;
    check("imem_req", imem_req, exp_req);
    if (outstanding) check("req_while_wait", imem_req, 1'b0);
    if (imem_req) check("imem_addr", imem_addr, exp_pc);
    granted = imem_req && imem_gnt;
    @(posedge clk);
    if (branch_taken) begin
      exp_q.delete();
      exp_pc = branch_target;
      if (outstanding) begin
        if (rv) outstanding = 1'b0;
        else killed = 1'b1;
      end
    end else if (rv && outstanding) begin
      if (!killed) exp_q.push_back({out_addr, imem_rdata});
      outstanding = 1'b0;
    end
    if (outstanding && !rv) lat_left--;
    if (granted) begin
      outstanding = 1'b1;
      killed = 1'b0;
      out_addr = exp_pc;
      exp_pc = exp_pc + 32'd4;
      lat_left = $urandom_range(lat_max, lat_min) - 1;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_granted(input int lat_after);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(outstanding && lat_left == lat_after) && n < 50);
    check("grant_timeout", (outstanding && lat_left == lat_after), 1'b1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [AW+IW-1:0] e;
    @(negedge clk);
    #1;
    if (!rst) begin
      check("if_valid", if_valid, exp_q.size() > 0);
      if (!if_valid) begin
        check("nop_inst", if_inst, '0);
        check("nop_pc", if_pc, '0);
      end
      if (if_valid && opc_chk) check("opcode", if_inst[31:26], 6'd1);
      if (if_valid && dbf_chk) check("no_deadbeef", if_inst == 32'hDEAD_BEEF, 1'b0);
      if (if_valid && !freeze && !branch_taken && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e[AW+IW-1:IW]);
        check("if_inst", if_inst, e[IW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    exp_pc = '0; outstanding = 1'b0; killed = 1'b0; out_addr = '0; lat_left = 0;
    gnt_pct = 100; frz_pct = 0; br_permil = 0; lat_min = 1; lat_max = 1;
    rand_data = 1'b0; force_br = 1'b0; stray_rv = 1'b0; force_tgt = '0;
    opc_chk = 1'b1; dbf_chk = 1'b1;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; freeze = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    // streaming with 1-cycle memory
    run(20);

    // freeze with buffer filling, then release
    frz_pct = 100; run(8);
    frz_pct = 0;   run(10);

    // redirect while waiting, stale data arrives two cycles later
    lat_min = 3; lat_max = 3;
    wait_granted(2);
    force_br = 1'b1; force_tgt = 32'h0000_0100; step(); force_br = 1'b0;
    run(15);

    // redirect in the same cycle as rvalid
    lat_min = 1; lat_max = 1;
    wait_granted(0);
    force_br = 1'b1; force_tgt = 32'h0000_0200; step(); force_br = 1'b0;
    run(10);

    // reset mid-wait, then a stray rvalid
    lat_min = 3; lat_max = 3;
    wait_granted(2);
    do_reset(1);
    stray_rv = 1'b1; step(); stray_rv = 1'b0;
    run(10);

    // pc wrap past the top of the address space
    lat_min = 1; lat_max = 1; opc_chk = 1'b0;
    force_br = 1'b1; force_tgt = 32'hFFFF_FFF8; step(); force_br = 1'b0;
    run(12);

    // random traffic
    rand_data = 1'b1; dbf_chk = 1'b0;
    gnt_pct = 60; frz_pct = 30; br_permil = 25; lat_min = 1; lat_max = 4;
    run(3000);
    gnt_pct = 100; frz_pct = 0; br_permil = 0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
